icache_ctrl: RTL and testbench

Direct-mapped, read-only instruction cache with a line-fill state machine. Sits directly upstream of the fetch stage: it takes the current PC and returns the instruction word plus the `imem_r` ready flag in the same cycle on a hit. On a miss it holds `imem_r` low while it refills the line from a multi-cycle backing memory over a req/ack handshake.

---
 rtl/lc3b_pkg.sv | 14 +
 rtl/icache_ctrl_if.sv | 37 +++
 rtl/icache_data_array.sv | 29 ++
 rtl/icache_ctrl.sv | 151 +++++++++++++++
 tb/tb_icache_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_pkg.sv
// Shared LC-3b constants and the instruction-cache FSM state type.
package lc3b_pkg;

    localparam int unsigned WORD_W            = 16;
    localparam int unsigned ICACHE_LINE_WORDS = 4;
    localparam int unsigned ICACHE_NUM_LINES  = 16;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } icache_state_t;

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side and backing-memory signals of the instruction cache.
// The master modport is the cache itself; slave is the fetch stage plus memory.
interface icache_ctrl_if;
    import lc3b_pkg::*;

    logic [WORD_W-1:0] pc;
    logic              inv;
    logic [WORD_W-1:0] instr;
    logic              imem_r;
    logic              mem_req;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  pc,
        input  inv,
        output instr,
        output imem_r,
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        output pc,
        output inv,
        input  instr,
        input  imem_r,
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/icache_data_array.sv
// Instruction-cache data store: combinational read, synchronous write, no reset.
module icache_data_array
    import lc3b_pkg::*;
#(
    parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int unsigned NUM_LINES  = ICACHE_NUM_LINES
) (
    input  logic                         clk,
    input  logic [$clog2(NUM_LINES)-1:0] rd_idx,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_off,
    output logic [WORD_W-1:0]            rd_data,
    input  logic                         we,
    input  logic [$clog2(NUM_LINES)-1:0] wr_idx,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_off,
    input  logic [WORD_W-1:0]            wr_data
);

    logic [WORD_W-1:0] mem [NUM_LINES*LINE_WORDS];

    assign rd_data = mem[{rd_idx, rd_off}];

    // Line-fill write port, one word per accepted beat.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_idx, wr_off}] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache with an in-order line-fill FSM.
module icache_ctrl
    import lc3b_pkg::*;
#(
    parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int unsigned NUM_LINES  = ICACHE_NUM_LINES
) (
    input  logic          clk,
    input  logic          rst_n,
    icache_ctrl_if.master bus
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = WORD_W - 1 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic             unused_pc0;

    icache_state_t     state_q, state_d;
    logic [TAG_W-1:0]  fill_tag_q, fill_tag_d;
    logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic              kill_q, kill_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q [NUM_LINES];
    logic              mem_req_q, mem_req_d;
    logic [WORD_W-1:0] mem_addr_q, mem_addr_d;

    logic              hit;
    logic              data_we;
    logic              tag_we;
    logic [WORD_W-1:0] rd_data;

    assign pc_off     = bus.pc[OFF_W:1];
    assign pc_idx     = bus.pc[OFF_W+IDX_W:OFF_W+1];
    assign pc_tag     = bus.pc[WORD_W-1:OFF_W+IDX_W+1];
    assign unused_pc0 = bus.pc[0];

    // Hits are only served from IDLE so a half-written line is never returned.
    assign hit = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

    assign bus.imem_r   = hit;
    assign bus.instr    = hit ? rd_data : '0;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;

    icache_data_array #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES)
    ) u_data (
        .clk     (clk),
        .rd_idx  (pc_idx),
        .rd_off  (pc_off),
        .rd_data (rd_data),
        .we      (data_we),
        .wr_idx  (fill_idx_q),
        .wr_off  (beat_q),
        .wr_data (bus.mem_rdata)
    );

    // Next-state, fill bookkeeping, valid/kill updates and registered bus outputs.
    always_comb begin
        state_d    = state_q;
        fill_tag_d = fill_tag_q;
        fill_idx_d = fill_idx_q;
        beat_d     = beat_q;
        kill_d     = kill_q;
        valid_d    = valid_q;
        data_we    = 1'b0;
        tag_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!hit && !bus.inv) begin
                    fill_tag_d = pc_tag;
                    fill_idx_d = pc_idx;
                    beat_d     = '0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (mem_req_q && bus.mem_ack) begin
                    data_we = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + OFF_W'(1);
                    end
                end
                // The line still completes, it just never becomes valid.
                if (bus.inv) begin
                    kill_d = 1'b1;
                end
            end
            DONE: begin
                tag_we = 1'b1;
                if (!kill_q) begin
                    valid_d[fill_idx_q] = 1'b1;
                end
                kill_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Invalidate wins over a line being validated in the same cycle.
        if (bus.inv) begin
            valid_d = '0;
        end

        mem_req_d  = (state_d == FILL);
        mem_addr_d = mem_req_d ? {fill_tag_d, fill_idx_d, beat_d, 1'b0} : mem_addr_q;
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            beat_q     <= '0;
            kill_q     <= 1'b0;
            valid_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_tag_q <= fill_tag_d;
            fill_idx_q <= fill_idx_d;
            beat_q     <= beat_d;
            kill_q     <= kill_d;
            valid_q    <= valid_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Tag store is written once per completed fill and is not reset.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[fill_idx_q] <= fill_tag_q;
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl against a line-level cache model.
module tb_icache_ctrl;
    import lc3b_pkg::*;

    localparam int unsigned LW = 4;
    localparam int unsigned NL = 16;

    logic clk = 1'b0;
    logic rst_n;

    icache_ctrl_if bus();

    icache_ctrl #(
        .LINE_WORDS (LW),
        .NUM_LINES  (NL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wait_states = 0;
    logic [15:0] addr_log [$];

    bit model_valid [NL];
    int model_tag   [NL];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a & 16'hFFFE) + 16'h1000;
    endfunction

    function automatic int f_idx(input logic [15:0] a);
        return (int'(a) / (2 * LW)) % NL;
    endfunction

    function automatic int f_tag(input logic [15:0] a);
        return int'(a) / (2 * LW * NL);
    endfunction

    function automatic bit model_hit(input logic [15:0] a);
        return model_valid[f_idx(a)] && (model_tag[f_idx(a)] == f_tag(a));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) model_valid[i] = 1'b0;
    endtask

    task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", name, obs, exp);
        end
    endtask

    // Backing memory: acks each beat after wait_states idle cycles, logs acked addresses.
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [15:0] prev_addr = '0;
    int          wcnt = 0;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && prev_req && !prev_ack && bus.mem_req)
            check("addr_stable", bus.mem_addr, prev_addr);
        if (bus.mem_req === 1'b1) begin
            if (wcnt >= wait_states) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_word(bus.mem_addr);
                addr_log.push_back(bus.mem_addr);
                wcnt = 0;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 16'hDEAD;
                wcnt++;
            end
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 16'hDEAD;
            wcnt = 0;
        end
        prev_req  = bus.mem_req;
        prev_ack  = bus.mem_ack;
        prev_addr = bus.mem_addr;
    end

    // One fetch of address a; inv_at>0 pulses inv that many cycles after the miss.
    task automatic fetch(input logic [15:0] a, input int waits, input int inv_at,
                         input bit skip_edge);
        int lat;
        int passes;
        int n;
        logic [15:0] base;
        if (!skip_edge) @(negedge clk);
        wait_states = waits;
        bus.pc  = a;
        bus.inv = 1'b0;
        #1;
        check("idle_req", {15'b0, bus.mem_req}, 16'd0);
        if (model_hit(a)) begin
            check("hit_r", {15'b0, bus.imem_r}, 16'd1);
            check("hit_instr", bus.instr, mem_word(a));
            return;
        end
        addr_log.delete();
        lat    = LW * (waits + 1) + 2;
        passes = (inv_at >= 1 && inv_at <= lat - 1) ? 2 : 1;
        base   = a & ~16'(2 * LW - 1);
        check("miss_r", {15'b0, bus.imem_r}, 16'd0);
        check("miss_instr", bus.instr, 16'h0000);
        for (int k = 1; k < passes * lat; k++) begin
            @(negedge clk);
            bus.inv = (k == inv_at);
            #1;
            check("fill_r", {15'b0, bus.imem_r}, 16'd0);
            if (k == 1) check("fill_req", {15'b0, bus.mem_req}, 16'd1);
            if (k == lat - 1) check("done_req", {15'b0, bus.mem_req}, 16'd0);
        end
        @(negedge clk);
        bus.inv = 1'b0;
        #1;
        check("ready_r", {15'b0, bus.imem_r}, 16'd1);
        check("ready_instr", bus.instr, mem_word(a));
        check("beat_count", 16'(addr_log.size()), 16'(passes * LW));
        n = addr_log.size();
        for (int k = 0; k < n && k < passes * LW; k++)
            check("beat_addr", addr_log[k], base + 16'(2 * (k % LW)));
        if (passes == 2) model_clear();
        model_valid[f_idx(a)] = 1'b1;
        model_tag[f_idx(a)]   = f_tag(a);
    endtask

    // One cycle of inv while in IDLE with pc=a.
    task automatic pulse_inv(input logic [15:0] a);
        @(negedge clk);
        bus.pc  = a;
        bus.inv = 1'b1;
        #1;
        check("inv_r", {15'b0, bus.imem_r}, {15'b0, model_hit(a)});
        model_clear();
    endtask

    logic [8:0]  tags [3];
    logic [15:0] ra;
    int          inv_at;

    initial begin
        tags[0] = 9'h060;
        tags[1] = 9'h061;
        tags[2] = 9'h1A3;
        model_clear();
        rst_n   = 1'b0;
        bus.pc  = 16'h3000;
        bus.inv = 1'b0;
        #1;
        check("rst_req", {15'b0, bus.mem_req}, 16'd0);
        check("rst_addr", bus.mem_addr, 16'h0000);
        check("rst_r", {15'b0, bus.imem_r}, 16'd0);
        check("rst_instr", bus.instr, 16'h0000);
        repeat (2) @(negedge clk);

        // Cold fetch, hits within the line, conflict misses.
        @(negedge clk);
        rst_n = 1'b1;
        fetch(16'h3000, 0, -1, 1'b1);
        fetch(16'h3002, 0, -1, 1'b0);
        fetch(16'h3004, 0, -1, 1'b0);
        fetch(16'h3006, 0, -1, 1'b0);
        fetch(16'h3080, 0, -1, 1'b0);
        fetch(16'h3000, 0, -1, 1'b0);

        // Two wait cycles per beat.
        fetch(16'h3010, 2, -1, 1'b0);
        fetch(16'h3016, 0, -1, 1'b0);

        // inv during beat 2 forces a second full fill.
        fetch(16'h3020, 0, 3, 1'b0);
        fetch(16'h3022, 0, -1, 1'b0);

        // inv together with an IDLE miss must not start a fill.
        pulse_inv(16'h3060);
        fetch(16'h3060, 0, -1, 1'b0);

        // Reset in the middle of a fill.
        @(negedge clk);
        bus.pc = 16'h3040;
        wait_states = 0;
        #1;
        check("pre_rst_r", {15'b0, bus.imem_r}, 16'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        check("pre_rst_req", {15'b0, bus.mem_req}, 16'd1);
        rst_n = 1'b0;
        #1;
        check("midfill_rst_req", {15'b0, bus.mem_req}, 16'd0);
        check("midfill_rst_r", {15'b0, bus.imem_r}, 16'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fetch(16'h3040, 0, -1, 1'b1);
        fetch(16'h3000, 1, -1, 1'b0);

        // Randomized fetches, waits and invalidates.
        for (int i = 0; i < 60; i++) begin
            ra = {tags[$urandom_range(0, 2)], 4'($urandom), 2'($urandom), 1'($urandom)};
            if ($urandom_range(0, 7) == 0) begin
                pulse_inv(ra);
            end else begin
                inv_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : -1;
                fetch(ra, int'($urandom_range(0, 2)), inv_at, 1'b0);
            end
        end

        @(negedge clk);
        bus.inv = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
